tmds_channel_encoder: RTL and testbench



---
 rtl/tmds_channel_encoder.sv | 134 +++++++++++++
 tb/tb_tmds_channel_encoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_encoder.sv
// TMDS 8b/10b channel encoder (DVI 1.0) with running-disparity tracking.
// Stage 1 builds the transition-minimised word, stage 2 the DC-balanced symbol.
module tmds_channel_encoder #(
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       de,
    input  logic [7:0] data,
    input  logic [1:0] c,
    output logic [9:0] dout
);

    localparam logic [9:0] TOK_C00 = 10'h354;
    localparam logic [9:0] TOK_C01 = 10'h0AB;
    localparam logic [9:0] TOK_C10 = 10'h154;
    localparam logic [9:0] TOK_C11 = 10'h2AB;

    function automatic logic [9:0] out_map(
        input logic [9:0] s
    );
        logic [9:0] r;
        r = s;
        if (BIT_REVERSE) begin
            for (int i = 0; i < 10; i++) begin
                r[i] = s[9-i];
            end
        end
        return r;
    endfunction

    logic [3:0] w_n1d;
    logic       w_use_xnor;
    logic [8:0] w_qm;
    logic [3:0] w_n1q;

    always_comb begin
        w_n1d = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n1d = w_n1d + {3'd0, data[i]};
        end
        w_use_xnor = (w_n1d > 4'd4)
                  || ((w_n1d == 4'd4) && !data[0]);
        w_qm    = 9'd0;
        w_qm[0] = data[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_qm[i-1] ^ data[i] ^ w_use_xnor;
        end
        w_qm[8] = ~w_use_xnor;
        w_n1q   = 4'd0;
        for (int i = 0; i < 8; i++) begin
            w_n1q = w_n1q + {3'd0, w_qm[i]};
        end
    end

    logic [8:0] r_qm;
    logic [3:0] r_n1q;
    logic       r_de;
    logic [1:0] r_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_qm  <= 9'd0;
            r_n1q <= 4'd0;
            r_de  <= 1'b0;
            r_c   <= 2'b00;
        end else begin
            r_qm  <= w_qm;
            r_n1q <= w_n1q;
            r_de  <= de;
            r_c   <= c;
        end
    end

    logic signed [4:0] r_cnt;
    logic signed [4:0] w_cnt_nxt;
    logic signed [4:0] w_diff;
    logic signed [4:0] w_q8x2;
    logic signed [4:0] w_nq8x2;
    logic [9:0]        w_sym;
    logic [9:0]        r_dout;
    logic              w_case_a;
    logic              w_case_b;

    // w_diff is n1q - n0q; all cnt arithmetic stays within -8..+8
    always_comb begin
        w_diff   = $signed({r_n1q, 1'b0} - 5'd8);
        w_q8x2   = $signed({3'd0, r_qm[8], 1'b0});
        w_nq8x2  = $signed({3'd0, ~r_qm[8], 1'b0});
        w_case_a = (r_cnt == 5'sd0) || (r_n1q == 4'd4);
        w_case_b = ((r_cnt > 5'sd0) && (r_n1q > 4'd4))
                || ((r_cnt < 5'sd0) && (r_n1q < 4'd4));
        w_sym     = TOK_C00;
        w_cnt_nxt = 5'sd0;
        if (r_de) begin
            unique case (1'b1)
                w_case_a: begin
                    w_sym = {~r_qm[8], r_qm[8],
                             r_qm[7:0] ^ {8{~r_qm[8]}}};
                    w_cnt_nxt = r_qm[8] ? r_cnt + w_diff
                                        : r_cnt - w_diff;
                end
                w_case_b: begin
                    w_sym     = {1'b1, r_qm[8], ~r_qm[7:0]};
                    w_cnt_nxt = r_cnt + w_q8x2 - w_diff;
                end
                default: begin
                    w_sym     = {1'b0, r_qm[8], r_qm[7:0]};
                    w_cnt_nxt = r_cnt - w_nq8x2 + w_diff;
                end
            endcase
        end else begin
            unique case (r_c)
                2'b00:   w_sym = TOK_C00;
                2'b01:   w_sym = TOK_C01;
                2'b10:   w_sym = TOK_C10;
                default: w_sym = TOK_C11;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= 5'sd0;
            r_dout <= out_map(TOK_C00);
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_dout <= out_map(w_sym);
        end
    end

    assign dout = r_dout;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed DVI cases plus
// random traffic against an arithmetic reference and a decoder round-trip.
module tb_tmds_channel_encoder;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       de;
    logic [7:0] data;
    logic [1:0] c;
    logic [9:0] dout_n;
    logic [9:0] dout_r;

    always #5 clock = ~clock;

    tmds_channel_encoder #(.BIT_REVERSE(1'b0)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .de     (de),
        .data   (data),
        .c      (c),
        .dout   (dout_n)
    );

    tmds_channel_encoder #(.BIT_REVERSE(1'b1)) dut_rev (
        .clock  (clock),
        .reset_n(reset_n),
        .de     (de),
        .data   (data),
        .c      (c),
        .dout   (dout_r)
    );

    typedef struct {
        int unsigned due;
        logic [9:0]  sym;
        logic        de;
        logic [7:0]  data;
        logic [1:0]  c;
    } exp_t;

    exp_t        sbq[$];
    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    int          mcnt  = 0;

    logic [9:0] tokens [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    logic [9:0] alt_exp[10] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF,
                                10'h100, 10'h3FF, 10'h100, 10'h3FF,
                                10'h100, 10'h100};
    logic [9:0] blk_exp[8] = '{10'h100, 10'h3FF, 10'h100, 10'h3FF,
                               10'h100, 10'h354, 10'h100, 10'h3FF};

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [9:0] bitrev(input logic [9:0] s);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = s[9-i];
        return r;
    endfunction

    // Standard DVI receiver decode: {is_ctrl, c, data}
    function automatic logic [10:0] tmds_decode(input logic [9:0] s);
        logic [7:0] q;
        logic [7:0] d;
        for (int k = 0; k < 4; k++) begin
            if (s == tokens[k]) return {1'b1, 2'(k), 8'h00};
        end
        q    = s[9] ? ~s[7:0] : s[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
        end
        return {1'b0, 2'b00, d};
    endfunction

    // Reference: DVI 1.0 encoding rules with integer disparity
    task automatic model_step(input logic d_e, input logic [7:0] d,
                              input logic [1:0] cc,
                              output logic [9:0] sym);
        int         ones;
        int         n1;
        int         n0;
        int         q8;
        bit         use_xnor;
        logic [8:0] q;
        if (!d_e) begin
            mcnt = 0;
            sym  = tokens[cc];
            return;
        end
        ones     = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? (q[i-1] ~^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = use_xnor ? 1'b0 : 1'b1;
        q8   = int'(q[8]);
        n1   = $countones(q[7:0]);
        n0   = 8 - n1;
        if (mcnt == 0 || n1 == n0) begin
            sym  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            mcnt = mcnt + (q[8] ? (n1 - n0) : (n0 - n1));
        end else if ((mcnt > 0 && n1 > n0) || (mcnt < 0 && n0 > n1)) begin
            sym  = {1'b1, q[8], ~q[7:0]};
            mcnt = mcnt + 2 * q8 + (n0 - n1);
        end else begin
            sym  = {1'b0, q[8], q[7:0]};
            mcnt = mcnt - 2 * (1 - q8) + (n1 - n0);
        end
    endtask

    task automatic issue(input logic d_e, input logic [7:0] d,
                         input logic [1:0] cc, input bit use_k,
                         input logic [9:0] k);
        logic [9:0] m;
        exp_t       e;
        @(posedge clock);
        #1;
        de   = d_e;
        data = d;
        c    = cc;
        model_step(d_e, d, cc, m);
        e.due  = cyc + 2;
        e.sym  = use_k ? k : m;
        e.de   = d_e;
        e.data = d;
        e.c    = cc;
        sbq.push_back(e);
    endtask

    task automatic check_now(input string name, input logic [9:0] act,
                             input logic [9:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
        end
    endtask

    exp_t        me;
    logic [10:0] dec_got;
    logic [10:0] dec_want;

    always @(negedge clock) begin
        while (sbq.size() != 0 && sbq[0].due < cyc) begin
            me = sbq.pop_front();
            total++;
            bad++;
            $display("FAIL missed cyc=%0d due=%0d", cyc, me.due);
        end
        if (sbq.size() != 0 && sbq[0].due == cyc) begin
            me = sbq.pop_front();
            total++;
            if (dout_n !== me.sym) begin
                bad++;
                $display("FAIL dout cyc=%0d de=%b d=%h c=%b got=%h want=%h",
                         cyc, me.de, me.data, me.c, dout_n, me.sym);
            end
            total++;
            if (dout_r !== bitrev(me.sym)) begin
                bad++;
                $display("FAIL dout_rev cyc=%0d got=%h want=%h",
                         cyc, dout_r, bitrev(me.sym));
            end
            dec_got  = tmds_decode(dout_n);
            dec_want = me.de ? {1'b0, 2'b00, me.data}
                             : {1'b1, me.c, 8'h00};
            total++;
            if (dec_got !== dec_want) begin
                bad++;
                $display("FAIL decode cyc=%0d got=%h want=%h",
                         cyc, dec_got, dec_want);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0;
        de      = 1'b0;
        data    = 8'h00;
        c       = 2'b00;
        repeat (3) @(posedge clock);
        #1;
        check_now("reset_dout", dout_n, 10'h354);
        check_now("reset_dout_rev", dout_r, 10'h0AB);
        reset_n = 1'b1;
        mcnt    = 0;

        repeat (3) issue(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);

        issue(1'b0, 8'h5A, 2'b00, 1'b1, 10'h354);
        issue(1'b0, 8'h5A, 2'b01, 1'b1, 10'h0AB);
        issue(1'b0, 8'h5A, 2'b10, 1'b1, 10'h154);
        repeat (3) issue(1'b0, 8'h5A, 2'b11, 1'b1, 10'h2AB);

        for (int i = 0; i < 10; i++) begin
            issue(1'b1, 8'h00, 2'b00, 1'b1, alt_exp[i]);
        end

        issue(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
        for (int i = 0; i < 8; i++) begin
            issue(i != 5, 8'h00, 2'b00, 1'b1, blk_exp[i]);
        end

        issue(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
        issue(1'b1, 8'hFF, 2'b00, 1'b1, 10'h200);
        issue(1'b1, 8'hFF, 2'b00, 1'b1, 10'h0FF);

        for (int i = 0; i < 6; i++) begin
            issue(1'b1, 8'(($urandom % 255) + 1), 2'b00, 1'b0, 10'h000);
        end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        sbq.delete();
        mcnt = 0;
        #1;
        check_now("async_reset", dout_n, 10'h354);
        check_now("async_reset_rev", dout_r, 10'h0AB);
        @(posedge clock);
        #1;
        check_now("reset_hold", dout_n, 10'h354);
        de      = 1'b0;
        c       = 2'b00;
        reset_n = 1'b1;
        repeat (2) issue(1'b0, 8'h00, 2'b00, 1'b1, 10'h354);
        issue(1'b1, 8'h00, 2'b00, 1'b1, 10'h100);

        for (int n = 0; n < 20000; n++) begin
            logic       rde;
            logic [7:0] rd;
            rde = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 5))
                0:       rd = 8'h00;
                1:       rd = 8'hFF;
                default: rd = 8'($urandom);
            endcase
            issue(rde, rd, 2'($urandom), 1'b0, 10'h000);
        end

        for (int w = 0; w < 10 && sbq.size() != 0; w++) begin
            @(posedge clock);
        end
        @(negedge clock);
        #1;
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain left=%0d", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
